// File: rtl/pim_dma_pkg.sv
// Shared types for the PIM DMA controller: FSM states, funct3 encodings and the command record.
package pim_dma_pkg;

    localparam int unsigned DMA_XLEN  = 32;
    localparam int unsigned DMA_CNT_W = 12;

    localparam logic [2:0] DMA_F3_MEM2PIM = 3'b000;
    localparam logic [2:0] DMA_F3_PIM2MEM = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_MEM_RD      = 3'd1,
        ST_MEM_RD_WAIT = 3'd2,
        ST_PIM_WR      = 3'd3,
        ST_PIM_RD      = 3'd4,
        ST_MEM_WR      = 3'd5,
        ST_DONE        = 3'd6
    } pim_dma_state_e;

    // dir: 0 = MEM->PIM, 1 = PIM->MEM
    typedef struct packed {
        logic                 dir;
        logic [3:0]           sel;
        logic [DMA_XLEN-1:0]  base;
        logic [DMA_CNT_W-1:0] words;
    } pim_dma_cmd_t;

    // Byte length rounded up to whole words.
    function automatic logic [DMA_CNT_W-1:0] size_to_words(input logic [12:0] size);
        logic [13:0] padded;
        padded = {1'b0, size} + 14'd3;
        return padded[13:2];
    endfunction

endpackage

// File: rtl/pim_dma_perf.sv
// Saturating busy-cycle and completed-word counters for pim_dma_ctrl (built only with PIM_DMA_PERF_EN).
module pim_dma_perf
    import pim_dma_pkg::*;
#(
    parameter int CNT_W = DMA_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             busy_i,
    input  logic             word_i,
    output logic [31:0]      cycles_o,
    output logic [CNT_W-1:0] words_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_o <= '0;
            words_o  <= '0;
        end else if (clear_i) begin
            cycles_o <= '0;
            words_o  <= '0;
        end else begin
            if (busy_i && !(&cycles_o)) cycles_o <= cycles_o + 32'd1;
            if (word_i && !(&words_o))  words_o  <= words_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pim_dma_ctrl.sv
// DMA engine moving words between data memory and a PIM unit while stalling the core.
// Optional PIM_DMA_PERF_EN adds perf_cycles_o / perf_words_o counters.
module pim_dma_ctrl
    import pim_dma_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dma_en_i,
    input  logic [2:0]       dma_funct3_i,
    input  logic [3:0]       dma_sel_pim_i,
    input  logic [12:0]      dma_size_i,
    input  logic [XLEN-1:0]  dma_mem_addr_i,
    output logic             dma_busy_o,
    output logic             req_dmem_o,
    input  logic             gnt_dmem_i,
    output logic [XLEN-1:0]  dmem_addr_o,
    input  logic [XLEN-1:0]  dmem_rd_data_i,
    output logic [XLEN-1:0]  dmem_wr_data_o,
    output logic [3:0]       dmem_size_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [3:0]       pim_sel_o,
    output logic [CNT_W-2:0] pim_addr_o,
    output logic             pim_wr_valid_o,
    output logic [XLEN-1:0]  pim_wr_data_o,
    input  logic             pim_wr_ready_i,
    output logic             pim_rd_req_o,
    input  logic             pim_rd_valid_i,
    input  logic [XLEN-1:0]  pim_rd_data_i
`ifdef PIM_DMA_PERF_EN
    ,
    output logic [31:0]      perf_cycles_o,
    output logic [CNT_W-1:0] perf_words_o
`endif
);

    localparam logic [XLEN-1:0]  ADDR_STEP = XLEN'(4);
    localparam logic [CNT_W-2:0] OFF_ONE   = (CNT_W-1)'(1);
    localparam logic [CNT_W-1:0] REM_ONE   = CNT_W'(1);

    pim_dma_state_e    state_q, state_d;
    pim_dma_cmd_t      cmd_d;
    logic              dir_q;
    logic [3:0]        sel_q;
    logic [XLEN-1:0]   addr_q;
    logic [CNT_W-1:0]  remain_q;
    logic [CNT_W-2:0]  offset_q;
    logic [XLEN-1:0]   buf_q;
    logic              busy_q;
    logic              cmd_accept;
    logic              word_done;

    assign cmd_d.dir   = (dma_funct3_i == DMA_F3_PIM2MEM);
    assign cmd_d.sel   = dma_sel_pim_i;
    assign cmd_d.base  = {dma_mem_addr_i[XLEN-1:2], 2'b00};
    assign cmd_d.words = size_to_words(dma_size_i);

    assign cmd_accept = (state_q == ST_IDLE) && dma_en_i &&
                        ((dma_funct3_i == DMA_F3_MEM2PIM) || (dma_funct3_i == DMA_F3_PIM2MEM));

    // Handshakes: a strobe (req_dmem/pim_wr_valid/pim_rd_req) is held with stable address and data
    // until its partner (gnt_dmem/pim_wr_ready/pim_rd_valid) is seen high on a rising edge.
    always_comb begin
        state_d   = state_q;
        word_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_d.words == '0) state_d = ST_DONE;
                    else if (cmd_d.dir)    state_d = ST_PIM_RD;
                    else                   state_d = ST_MEM_RD;
                end
            end
            ST_MEM_RD:      if (gnt_dmem_i) state_d = ST_MEM_RD_WAIT;
            ST_MEM_RD_WAIT: state_d = ST_PIM_WR;
            ST_PIM_WR:      word_done = pim_wr_ready_i;
            ST_PIM_RD:      if (pim_rd_valid_i) state_d = ST_MEM_WR;
            ST_MEM_WR:      word_done = gnt_dmem_i;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        if (word_done) begin
            if (remain_q == REM_ONE) state_d = ST_DONE;
            else if (dir_q)          state_d = ST_PIM_RD;
            else                     state_d = ST_MEM_RD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q    <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            offset_q <= '0;
            buf_q    <= '0;
        end else begin
            if (cmd_accept) begin
                dir_q    <= cmd_d.dir;
                sel_q    <= cmd_d.sel;
                addr_q   <= cmd_d.base;
                remain_q <= cmd_d.words;
                offset_q <= '0;
            end else if (word_done) begin
                addr_q   <= addr_q + ADDR_STEP;
                offset_q <= offset_q + OFF_ONE;
                remain_q <= remain_q - REM_ONE;
            end
            // Read data arrives the cycle after the granted read.
            if (state_q == ST_MEM_RD_WAIT) buf_q <= dmem_rd_data_i;
            else if ((state_q == ST_PIM_RD) && pim_rd_valid_i) buf_q <= pim_rd_data_i;
        end
    end

    always_comb begin
        req_dmem_o     = 1'b0;
        dmem_read_o    = 1'b0;
        dmem_write_o   = 1'b0;
        dmem_size_o    = 4'b0000;
        dmem_addr_o    = '0;
        dmem_wr_data_o = '0;
        pim_wr_valid_o = 1'b0;
        pim_wr_data_o  = '0;
        pim_rd_req_o   = 1'b0;
        case (state_q)
            ST_MEM_RD: begin
                req_dmem_o  = 1'b1;
                dmem_read_o = 1'b1;
                dmem_size_o = 4'b1111;
                dmem_addr_o = addr_q;
            end
            ST_MEM_WR: begin
                req_dmem_o     = 1'b1;
                dmem_write_o   = 1'b1;
                dmem_size_o    = 4'b1111;
                dmem_addr_o    = addr_q;
                dmem_wr_data_o = buf_q;
            end
            ST_PIM_WR: begin
                pim_wr_valid_o = 1'b1;
                pim_wr_data_o  = buf_q;
            end
            ST_PIM_RD: pim_rd_req_o = 1'b1;
            default: ;
        endcase
    end

    assign dma_busy_o = busy_q;
    assign pim_sel_o  = sel_q;
    assign pim_addr_o = offset_q;

`ifdef PIM_DMA_PERF_EN
    pim_dma_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cmd_accept),
        .busy_i   (state_q != ST_IDLE),
        .word_i   (word_done),
        .cycles_o (perf_cycles_o),
        .words_o  (perf_words_o)
    );
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Self-checking bench for pim_dma_ctrl: transaction-level reference model, randomized responders.
module tb_pim_dma_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 12;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic             dma_en_i;
    logic [2:0]       dma_funct3_i;
    logic [3:0]       dma_sel_pim_i;
    logic [12:0]      dma_size_i;
    logic [XLEN-1:0]  dma_mem_addr_i;
    logic             dma_busy_o;
    logic             req_dmem_o;
    logic             gnt_dmem_i;
    logic [XLEN-1:0]  dmem_addr_o;
    logic [XLEN-1:0]  dmem_rd_data_i;
    logic [XLEN-1:0]  dmem_wr_data_o;
    logic [3:0]       dmem_size_o;
    logic             dmem_read_o;
    logic             dmem_write_o;
    logic [3:0]       pim_sel_o;
    logic [CNT_W-2:0] pim_addr_o;
    logic             pim_wr_valid_o;
    logic [XLEN-1:0]  pim_wr_data_o;
    logic             pim_wr_ready_i;
    logic             pim_rd_req_o;
    logic             pim_rd_valid_i;
    logic [XLEN-1:0]  pim_rd_data_i;

    pim_dma_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .dma_en_i       (dma_en_i),
        .dma_funct3_i   (dma_funct3_i),
        .dma_sel_pim_i  (dma_sel_pim_i),
        .dma_size_i     (dma_size_i),
        .dma_mem_addr_i (dma_mem_addr_i),
        .dma_busy_o     (dma_busy_o),
        .req_dmem_o     (req_dmem_o),
        .gnt_dmem_i     (gnt_dmem_i),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_rd_data_i (dmem_rd_data_i),
        .dmem_wr_data_o (dmem_wr_data_o),
        .dmem_size_o    (dmem_size_o),
        .dmem_read_o    (dmem_read_o),
        .dmem_write_o   (dmem_write_o),
        .pim_sel_o      (pim_sel_o),
        .pim_addr_o     (pim_addr_o),
        .pim_wr_valid_o (pim_wr_valid_o),
        .pim_wr_data_o  (pim_wr_data_o),
        .pim_wr_ready_i (pim_wr_ready_i),
        .pim_rd_req_o   (pim_rd_req_o),
        .pim_rd_valid_i (pim_rd_valid_i),
        .pim_rd_data_i  (pim_rd_data_i)
    );

    // ---------------- scoreboard / model state ----------------
    typedef enum {M_IDLE, M_XFER, M_DONE} mphase_e;
    mphase_e     ph;
    logic        m_dir;
    logic [3:0]  m_sel;
    logic [31:0] m_base;
    int          m_words, m_done;

    logic [63:0] exp_rd_q[$];   // expected memory read addresses
    logic [63:0] exp_pwr_q[$];  // {offset, data} expected PIM writes
    logic [63:0] exp_prd_q[$];  // expected PIM read offsets
    logic [63:0] exp_mwr_q[$];  // {addr, data} expected memory writes
    logic [31:0] rd_log[$], mwr_log[$], off_log[$];

    int checks, failures, busy_cycles;
    int gnt_cfg, rdy_cfg, gwait, rwait, vwait;
    logic held_mem, held_pwr, held_prd, rd_pend, noise_en, cmd_pending;
    logic [31:0] rd_pend_addr, prev_addr, prev_wdata, prev_pdata;
    logic [2:0]  prev_strb;
    logic [10:0] prev_off;
    logic [2:0]  c_f3;
    logic [3:0]  c_sel;
    logic [12:0] c_size;
    logic [31:0] c_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'hA5C3_0F96 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] pim_val(input logic [3:0] s, input logic [31:0] o);
        return {s, o[11:0], 16'h5A00 ^ o[15:0]};
    endfunction

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    // Builds the expected transaction lists of an accepted command.
    task automatic load_model(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                              input logic [31:0] addr);
        logic [31:0] a;
        m_dir   = f3[0];
        m_sel   = sel;
        m_base  = addr & 32'hFFFF_FFFC;
        m_words = (int'(size) + 3) / 4;
        m_done  = 0;
        for (int i = 0; i < m_words; i++) begin
            a = m_base + 32'(4 * i);
            if (!m_dir) begin
                exp_rd_q.push_back(64'(a));
                exp_pwr_q.push_back({32'(i), mem_val(a)});
            end else begin
                exp_prd_q.push_back(64'(i));
                exp_mwr_q.push_back({a, pim_val(sel, 32'(i))});
            end
        end
        ph = (m_words == 0) ? M_DONE : M_XFER;
    endtask

    // ---------------- per-cycle compare + drive ----------------
    task automatic step();
        logic gnt, rdy, vld, wc;
        logic [63:0] e;
        mphase_e ph_now;
        @(negedge clk_i);
        ph_now = ph;
        check("busy", dma_busy_o, ph_now != M_IDLE);
        if (dma_busy_o) busy_cycles++;
        if (ph_now != M_XFER) begin
            check("strobes_quiet", {req_dmem_o, dmem_read_o, dmem_write_o, pim_wr_valid_o,
                                    pim_rd_req_o, dmem_size_o}, 0);
        end else begin
            check("dmem_size", dmem_size_o, req_dmem_o ? 4'hF : 4'h0);
            check("req_vs_strobe", req_dmem_o, dmem_read_o | dmem_write_o);
            check("dir_strobes", m_dir ? {dmem_read_o, pim_wr_valid_o} : {dmem_write_o, pim_rd_req_o}, 0);
            check("pim_sel", pim_sel_o, m_sel);
        end
        if (held_mem) begin
            check("mem_hold_strb", {req_dmem_o, dmem_read_o, dmem_write_o}, prev_strb);
            check("mem_hold_addr", dmem_addr_o, prev_addr);
            check("mem_hold_data", dmem_wr_data_o, prev_wdata);
        end
        if (held_pwr) begin
            check("pwr_hold_valid", pim_wr_valid_o, 1'b1);
            check("pwr_hold_data", pim_wr_data_o, prev_pdata);
            check("pwr_hold_off", pim_addr_o, prev_off);
        end
        if (held_prd) begin
            check("prd_hold_req", pim_rd_req_o, 1'b1);
            check("prd_hold_off", pim_addr_o, prev_off);
        end

        dmem_rd_data_i = rd_pend ? mem_val(rd_pend_addr) : $urandom;
        rd_pend = 1'b0;
        gnt = 1'b0; rdy = 1'b0; vld = 1'b0; wc = 1'b0;
        if (req_dmem_o) begin
            if (!held_mem) gwait = pick(gnt_cfg);
            if (gwait == 0) gnt = 1'b1; else gwait--;
        end
        if (pim_wr_valid_o) begin
            if (!held_pwr) rwait = pick(rdy_cfg);
            if (rwait == 0) rdy = 1'b1; else rwait--;
        end
        if (pim_rd_req_o) begin
            if (!held_prd) vwait = pick(rdy_cfg);
            if (vwait == 0) vld = 1'b1; else vwait--;
        end

        if (gnt && dmem_read_o) begin
            if (exp_rd_q.size() == 0) check("unexpected_mem_rd", 1, 0);
            else begin
                e = exp_rd_q.pop_front();
                check("mem_rd_addr", dmem_addr_o, e[31:0]);
                rd_pend = 1'b1; rd_pend_addr = e[31:0];
                rd_log.push_back(dmem_addr_o);
            end
        end
        if (gnt && dmem_write_o) begin
            if (exp_mwr_q.size() == 0) check("unexpected_mem_wr", 1, 0);
            else begin
                e = exp_mwr_q.pop_front();
                check("mem_wr_addr", dmem_addr_o, e[63:32]);
                check("mem_wr_data", dmem_wr_data_o, e[31:0]);
                mwr_log.push_back(dmem_addr_o);
                wc = 1'b1;
            end
        end
        if (rdy) begin
            if (exp_pwr_q.size() == 0) check("unexpected_pim_wr", 1, 0);
            else begin
                e = exp_pwr_q.pop_front();
                check("pim_wr_off", pim_addr_o, e[42:32]);
                check("pim_wr_data", pim_wr_data_o, e[31:0]);
                off_log.push_back(32'(pim_addr_o));
                wc = 1'b1;
            end
        end
        pim_rd_data_i = $urandom;
        if (vld) begin
            if (exp_prd_q.size() == 0) check("unexpected_pim_rd", 1, 0);
            else begin
                e = exp_prd_q.pop_front();
                check("pim_rd_off", pim_addr_o, e[10:0]);
                pim_rd_data_i = pim_val(m_sel, e[31:0]);
                off_log.push_back(32'(pim_addr_o));
            end
        end
        gnt_dmem_i = gnt; pim_wr_ready_i = rdy; pim_rd_valid_i = vld;
        held_mem = req_dmem_o && !gnt;
        held_pwr = pim_wr_valid_o && !rdy;
        held_prd = pim_rd_req_o && !vld;
        prev_strb = {req_dmem_o, dmem_read_o, dmem_write_o};
        prev_addr = dmem_addr_o; prev_wdata = dmem_wr_data_o;
        prev_pdata = pim_wr_data_o; prev_off = pim_addr_o;

        if (ph_now == M_DONE) begin
            ph = M_IDLE;
            check("leftover_xfers", exp_rd_q.size() + exp_pwr_q.size() + exp_prd_q.size() + exp_mwr_q.size(), 0);
        end else if (ph_now == M_XFER && wc) begin
            m_done++;
            if (m_done == m_words) ph = M_DONE;
        end

        dma_en_i = 1'b0;
        dma_funct3_i = 3'($urandom); dma_sel_pim_i = 4'($urandom);
        dma_size_i = 13'($urandom); dma_mem_addr_i = $urandom;
        if (cmd_pending) begin
            dma_en_i = 1'b1; dma_funct3_i = c_f3; dma_sel_pim_i = c_sel;
            dma_size_i = c_size; dma_mem_addr_i = c_addr;
            cmd_pending = 1'b0;
            if (ph_now == M_IDLE && c_f3 <= 3'b001) load_model(c_f3, c_sel, c_size, c_addr);
        end else if (noise_en && ph_now != M_IDLE && $urandom_range(0, 5) == 0) begin
            dma_en_i = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        busy_cycles = 0;
        rd_log.delete(); mwr_log.delete(); off_log.delete();
    endtask

    task automatic start_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                             input logic [31:0] addr);
        clear_logs();
        c_f3 = f3; c_sel = sel; c_size = size; c_addr = addr;
        cmd_pending = 1'b1;
        step();
    endtask

    task automatic run_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                           input logic [31:0] addr);
        int n;
        start_cmd(f3, sel, size, addr);
        n = 0;
        while (ph != M_IDLE && n < 3000) begin
            step();
            n++;
        end
        if (ph != M_IDLE) begin
            checks++; failures++;
            $display("FAIL xfer_timeout actual=%0d_words required=%0d_words", m_done, m_words);
            ph = M_IDLE;
            exp_rd_q.delete(); exp_pwr_q.delete(); exp_prd_q.delete(); exp_mwr_q.delete();
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        dma_en_i = 1'b0; gnt_dmem_i = 1'b0; pim_wr_ready_i = 1'b0; pim_rd_valid_i = 1'b0;
        #1;
        check("rst_ctrl", {dma_busy_o, req_dmem_o, dmem_read_o, dmem_write_o, pim_wr_valid_o, pim_rd_req_o}, 0);
        check("rst_dmem_addr", dmem_addr_o, 0);
        check("rst_dmem_wdata", dmem_wr_data_o, 0);
        check("rst_dmem_size", dmem_size_o, 0);
        check("rst_pim_sel_addr", {pim_sel_o, pim_addr_o}, 0);
        check("rst_pim_wdata", pim_wr_data_o, 0);
        ph = M_IDLE;
        exp_rd_q.delete(); exp_pwr_q.delete(); exp_prd_q.delete(); exp_mwr_q.delete();
        held_mem = 1'b0; held_pwr = 1'b0; held_prd = 1'b0; rd_pend = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        checks = 0; failures = 0; busy_cycles = 0;
        ph = M_IDLE; m_words = 0; m_done = 0; m_dir = 1'b0; m_sel = '0; m_base = '0;
        gnt_cfg = 0; rdy_cfg = 0; gwait = 0; rwait = 0; vwait = 0;
        held_mem = 1'b0; held_pwr = 1'b0; held_prd = 1'b0; rd_pend = 1'b0;
        noise_en = 1'b0; cmd_pending = 1'b0;
        rd_pend_addr = '0; prev_addr = '0; prev_wdata = '0; prev_pdata = '0; prev_strb = '0; prev_off = '0;
        c_f3 = '0; c_sel = '0; c_size = '0; c_addr = '0;
        dma_funct3_i = '0; dma_sel_pim_i = '0; dma_size_i = '0; dma_mem_addr_i = '0;
        dmem_rd_data_i = '0; pim_rd_data_i = '0;
        rst_ni = 1'b0;
        apply_reset();
        repeat (2) step();

        // MEM->PIM, zero wait, unaligned base
        run_cmd(3'b000, 4'd5, 13'd16, 32'h2000_0006);
        check("t1_busy_cycles", busy_cycles, 13);
        check("t1_rd_count", rd_log.size(), 4);
        check("t1_rd_first", rd_log[0], 32'h2000_0004);
        check("t1_rd_last", rd_log[3], 32'h2000_0010);
        check("t1_off_first", off_log[0], 0);
        check("t1_off_last", off_log[3], 3);

        // PIM->MEM, partial final word
        run_cmd(3'b001, 4'd3, 13'd5, 32'h0000_0100);
        check("t2_busy_cycles", busy_cycles, 5);
        check("t2_wr_count", mwr_log.size(), 2);
        check("t2_wr_addr1", mwr_log[1], 32'h0000_0104);

        // Illegal funct3
        run_cmd(3'b010, 4'd1, 13'd8, 32'h0000_0040);
        repeat (3) step();
        check("t3_busy_cycles", busy_cycles, 0);
        check("t3_no_traffic", rd_log.size() + mwr_log.size() + off_log.size(), 0);

        // Zero-length command
        run_cmd(3'b000, 4'd2, 13'd0, 32'h0000_0080);
        step();
        check("t4_busy_cycles", busy_cycles, 1);
        check("t4_no_traffic", rd_log.size() + off_log.size(), 0);

        // Withheld grant (5) and ready/valid (3)
        gnt_cfg = 5; rdy_cfg = 3;
        run_cmd(3'b000, 4'd9, 13'd8, 32'h0000_1000);
        check("t5_m2p_busy", busy_cycles, 23);
        run_cmd(3'b001, 4'd9, 13'd8, 32'h0000_2000);
        check("t5_p2m_busy", busy_cycles, 21);
        gnt_cfg = 0; rdy_cfg = 0;

        // Reset in the middle of word 2, then a fresh command
        start_cmd(3'b000, 4'd7, 13'd16, 32'h0000_0200);
        n = 0;
        while (m_done < 2 && n < 500) begin step(); n++; end
        step();
        apply_reset();
        run_cmd(3'b001, 4'd4, 13'd12, 32'h0000_0300);
        check("t6_off_count", off_log.size(), 3);
        check("t6_off_first", off_log[0], 0);
        check("t6_wr_first", mwr_log[0], 32'h0000_0300);

        // Randomized traffic with random waits and stray strobes while busy
        gnt_cfg = -1; rdy_cfg = -1; noise_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            run_cmd(3'($urandom_range(0, 3)), 4'($urandom), 13'($urandom_range(0, 40)),
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF2 : $urandom);
            if ($urandom_range(0, 1) == 1) step();
        end
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/pim_dma_ctrl.md
# pim_dma_ctrl

DMA controller sitting directly downstream of the core's DMA command interface. Accepts a one-cycle transfer command from the core's EX stage and holds the core stalled through `dma_busy_o` while it moves words between data memory and one of up to 16 PIM units. It masters the shared data-memory port through the existing request/grant arbiter. The core never requests data memory while busy is high.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `CNT_W`, 12, word-counter width; holds up to 2048 words.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `dma_en_i`  in  1  command strobe, one cycle.
- `dma_funct3_i`  in  3  direction: `3'b000` is MEM→PIM, `3'b001` is PIM→MEM, any other value is illegal.
- `dma_sel_pim_i`  in  4  target PIM unit.
- `dma_size_i`  in  13  transfer length in bytes.
- `dma_mem_addr_i`  in  XLEN  data-memory start address.
- `dma_busy_o`  out  1  transfer in progress; stalls the core.
- `req_dmem_o`  out  1  data-memory bus request.
- `gnt_dmem_i`  in  1  data-memory bus grant.
- `dmem_addr_o`  out  XLEN  word address.
- `dmem_rd_data_i`  in  XLEN  read data, valid one cycle after a granted read.
- `dmem_wr_data_o`  out  XLEN  write data.
- `dmem_size_o`  out  4  byte enables; `4'b1111` when active.
- `dmem_read_o`  out  1  read strobe.
- `dmem_write_o`  out  1  write strobe.
- `pim_sel_o`  out  4  latched unit select.
- `pim_addr_o`  out  CNT_W-1  word offset within the PIM unit.
- `pim_wr_valid_o`  out  1  write data valid.
- `pim_wr_data_o`  out  XLEN  write data.
- `pim_wr_ready_i`  in  1  PIM accepts the write.
- `pim_rd_req_o`  out  1  read request.
- `pim_rd_valid_i`  in  1  read data valid.
- `pim_rd_data_i`  in  XLEN  read data.

## Operation
- States: IDLE, MEM_RD, MEM_RD_WAIT, PIM_WR, PIM_RD, MEM_WR, DONE.
- IDLE with `dma_en_i`=1 and a legal funct3:
  - Latch direction, `pim_sel`, base address with bits [1:0] cleared, and `words = ceil(dma_size_i/4)`.
  - Clear the PIM offset.
  - If `words`=0, go to DONE. Otherwise go to MEM_RD for MEM→PIM, or PIM_RD for PIM→MEM.
- IDLE with an illegal funct3: ignore the command; busy stays low.
- MEM→PIM, per word:
  - MEM_RD: drive `req_dmem_o`=`dmem_read_o`=1 and the address. Hold until `gnt_dmem_i`, then go to MEM_RD_WAIT.
  - MEM_RD_WAIT: capture `dmem_rd_data_i` into the 1-word buffer, then go to PIM_WR.
  - PIM_WR: hold `pim_wr_valid_o`=1 with stable data and offset until `pim_wr_ready_i`.
- PIM→MEM, per word:
  - PIM_RD: hold `pim_rd_req_o`=1 until `pim_rd_valid_i`; capture data in that same cycle, then go to MEM_WR.
  - MEM_WR: drive `req_dmem_o`=`dmem_write_o`=1 with the buffer until `gnt_dmem_i`.
- Word completion: when the final handshake of a word completes, address += 4 (wraps mod 2^XLEN), offset += 1, remaining −= 1. At remaining=0, go to DONE; otherwise start the next word.
- DONE: lasts one cycle, then goes to IDLE.
- `dma_en_i` is ignored outside IDLE.
- All bus/PIM strobes are 0 in IDLE and DONE. `dmem_size_o`=0 when no access is in progress.

## Timing
- Reset: all outputs 0, state IDLE, all counters and the buffer 0.
- `dma_busy_o` is registered, equal to (state≠IDLE). It rises the cycle after the command strobe. The core's own `ex.dma_en` covers the strobe cycle, so there is no stall gap.
- Best case with zero-wait grant/ready:
  - MEM→PIM: 3 cycles per word.
  - PIM→MEM: 2 cycles per word.
  - Plus 1 cycle for DONE.
- Busy falls the cycle after DONE. The core resumes on that edge.
- Reset mid-transfer: abort immediately. No partial-word completion is required.
- Grant/ready waits are unbounded; strobes, address and data stay stable throughout.

## Configuration
- `PIM_DMA_PERF_EN` defined: adds the following outputs. Both clear on the accept cycle and saturate at all-ones.
  - `perf_cycles_o` (32): counts busy cycles of the last/current transfer.
  - `perf_words_o` (CNT_W): counts completed words.
- Not defined: these ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- `pim_dma_pkg` holds:
  - The state enum `pim_dma_state_e`.
  - `DMA_F3_MEM2PIM`=3'b000 and `DMA_F3_PIM2MEM`=3'b001.
  - The `pim_dma_cmd_t` struct: dir, sel, base, words.
- One sub-module, `pim_dma_perf`, holding the saturating counters. It is instantiated only under `PIM_DMA_PERF_EN`. The FSM and datapath are flat in `pim_dma_ctrl`.

## Test plan
- MEM→PIM, size=16, addr=0x2000_0006, zero-wait:
  - Reads hit 0x2000_0004..0x2000_0010.
  - PIM offsets 0..3.
  - Busy high for 13 cycles.
- PIM→MEM, size=5, sel=3: 2 words are written with `dmem_size_o`=4'b1111 and `pim_sel_o`=3.
- Command with funct3=3'b010: busy stays 0 and no strobes are issued.
- size=0 command: busy high exactly 1 cycle (DONE); no bus activity.
- `gnt_dmem_i` withheld 5 cycles and `pim_wr_ready_i` withheld 3 cycles: strobes and address/data are held stable and the data is delivered intact.
- Reset asserted mid-transfer at word 2, then a new command: outputs go to 0 immediately and the new transfer starts at offset 0.
